// File: rtl/button_event_pkg.sv
// button_event_pkg: constants, parser states and event widths shared by button_event_rx.
// BUTTON_EVENT_TIMESTAMP_EN adds a 16-bit cycle/1024 timestamp to each event.
package button_event_pkg;
    localparam logic [7:0] CMD_ID_DEF  = 8'hF4;
    localparam int         FRAME_LEN   = 5;
    localparam int         PAYLOAD_LEN = FRAME_LEN - 1;
    localparam int         TS_W        = 16;
    localparam int         TS_DIV_W    = 10;

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_PAYLOAD, ST_DISCARD} parser_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int evt_w(input int n);
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        return TS_W + 1 + idx_w(n);
`else
        return 1 + idx_w(n);
`endif
    endfunction
endpackage

// File: rtl/button_event_fifo.sv
// button_event_fifo: first-word-fall-through circular buffer with full/empty flags.
module button_event_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         resetq,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        full    = cnt_q == CW'(DEPTH);
        empty   = cnt_q == '0;
        do_push = push && !full;
        do_pop  = pop && !empty;
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = wdata;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        rdata   = mem_q[rd_q];
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/button_event_rx.sv
// button_event_rx: parses 0xF4 button frames, keeps masked button state, queues press/release events.
// BUTTON_EVENT_TIMESTAMP_EN prefixes each event with a 16-bit cycle/1024 timestamp.
module button_event_rx
    import button_event_pkg::*;
#(
    parameter logic [7:0] CMD_ID     = CMD_ID_DEF,
    parameter int         NBTN       = 16,
    parameter int         FIFO_DEPTH = 8,
    localparam int        IW         = idx_w(NBTN),
    localparam int        EW         = evt_w(NBTN)
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic [7:0]      usr_mosi_data,
    input  logic            usr_mosi_stb,
    input  logic            csn_fall,
    input  logic            csn_rise,
    output logic [NBTN-1:0] btn_state,
    output logic            btn_valid,
    output logic            evt_valid,
    output logic [EW-1:0]   evt_data,
    input  logic            evt_ready,
    output logic            frame_err
);
    parser_state_e   st_q, st_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     buf_q, buf_d;
    logic [NBTN-1:0] btn_state_q, btn_state_d, pend_q, pend_d;
    logic [NBTN-1:0] mask, state, diff, clr;
    logic            btn_valid_q, btn_valid_d, frame_err_q, frame_err_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            hit, push, full, empty;
    logic [EW-1:0]   wdata;

    // A byte arriving with csn_rise is counted before the rise is judged.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        btn_state_d = btn_state_q;
        btn_valid_d = btn_valid_q;
        frame_err_d = 1'b0;
        diff        = '0;
        if (usr_mosi_stb && st_q == ST_CMD) st_d = (usr_mosi_data == CMD_ID) ? ST_PAYLOAD : ST_DISCARD;
        if (usr_mosi_stb && st_q == ST_PAYLOAD) begin
            buf_d = {buf_q[23:0], usr_mosi_data};
            cnt_d = (cnt_q == 3'(FRAME_LEN)) ? cnt_q : cnt_q + 3'd1;
        end
        mask  = buf_d[16 +: NBTN];
        state = buf_d[0 +: NBTN];
        if (csn_rise && st_d == ST_PAYLOAD && cnt_d == 3'(PAYLOAD_LEN)) begin
            btn_state_d = (btn_state_q & ~mask) | (state & mask);
            btn_valid_d = 1'b1;
            diff        = btn_state_d ^ btn_state_q;
        end
        frame_err_d = csn_rise && st_d == ST_PAYLOAD && cnt_d != 3'(PAYLOAD_LEN);
        if (csn_rise) st_d = ST_IDLE;
        if (csn_fall) begin
            st_d  = ST_CMD;
            cnt_d = '0;
        end
    end

    // Round-robin scanner; a pending bit blocked by a full FIFO holds the pointer.
    always_comb begin
        hit    = pend_q[ptr_q];
        push   = hit && !full;
        clr    = push ? NBTN'(1) << ptr_q : '0;
        ptr_d  = (hit && full) ? ptr_q : (ptr_q == IW'(NBTN - 1)) ? '0 : ptr_q + 1'b1;
        pend_d = (pend_q & ~clr) ^ diff;
    end

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [TS_W+TS_DIV_W-1:0] tick_q, tick_d;
    assign tick_d = tick_q + 1'b1;
    assign wdata  = {tick_q[TS_DIV_W +: TS_W], btn_state_q[ptr_q], ptr_q};
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) tick_q <= '0;
        else         tick_q <= tick_d;
    end
`else
    assign wdata = {btn_state_q[ptr_q], ptr_q};
`endif

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            st_q        <= ST_IDLE;
            cnt_q       <= '0;
            buf_q       <= '0;
            btn_state_q <= '0;
            btn_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            pend_q      <= '0;
            ptr_q       <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            btn_state_q <= btn_state_d;
            btn_valid_q <= btn_valid_d;
            frame_err_q <= frame_err_d;
            pend_q      <= pend_d;
            ptr_q       <= ptr_d;
        end
    end

    button_event_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (push),
        .wdata  (wdata),
        .pop    (evt_ready),
        .rdata  (evt_data),
        .full   (full),
        .empty  (empty)
    );

    assign btn_state = btn_state_q;
    assign btn_valid = btn_valid_q;
    assign frame_err = frame_err_q;
    assign evt_valid = !empty;
endmodule

// File: tb/tb_button_event_rx.sv
// tb_button_event_rx: random and directed frames checked every cycle against a queue-based model.
module tb_button_event_rx;
    localparam int NBTN  = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic [7:0]  usr_mosi_data = '0;
    logic        usr_mosi_stb = 1'b0;
    logic        csn_fall = 1'b0;
    logic        csn_rise = 1'b0;
    logic [15:0] btn_state;
    logic        btn_valid;
    logic        evt_valid;
    logic [4:0]  evt_data;
    logic        evt_ready = 1'b0;
    logic        frame_err;

    int tests = 0;
    int fails = 0;
    int ready_mode = 0;
    int err_seen = 0;
    logic [7:0] fr[$];
    logic [4:0] popped[$];

    // Model: frame bytes since csn_fall, button/pending words, FIFO as a queue.
    logic [15:0] m_btn = '0, m_pend = '0;
    logic        m_valid = 1'b0, m_err = 1'b0, m_inf = 1'b0;
    int          m_ptr = 0;
    logic [4:0]  m_q[$];
    logic [7:0]  m_bytes[$];

    button_event_rx dut (
        .clk           (clk),
        .resetq        (resetq),
        .usr_mosi_data (usr_mosi_data),
        .usr_mosi_stb  (usr_mosi_stb),
        .csn_fall      (csn_fall),
        .csn_rise      (csn_rise),
        .btn_state     (btn_state),
        .btn_valid     (btn_valid),
        .evt_valid     (evt_valid),
        .evt_data      (evt_data),
        .evt_ready     (evt_ready),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge resetq) begin
        logic [15:0] diff, nb, msk, st, clr;
        logic        do_pop, do_push;
        logic [4:0]  pe;
        if (!resetq) begin
            m_btn = '0; m_pend = '0; m_valid = 1'b0; m_err = 1'b0; m_inf = 1'b0;
            m_ptr = 0; m_q.delete(); m_bytes.delete();
        end else begin
            diff = '0;
            m_err = 1'b0;
            do_pop = m_q.size() > 0 && evt_ready;
            do_push = m_pend[m_ptr] && m_q.size() < DEPTH;
            pe = {m_btn[m_ptr], 4'(m_ptr)};
            clr = do_push ? (16'h1 << m_ptr) : 16'h0;
            if (!(m_pend[m_ptr] && !do_push)) m_ptr = (m_ptr + 1) % NBTN;
            if (usr_mosi_stb && m_inf) m_bytes.push_back(usr_mosi_data);
            if (csn_rise && m_inf) begin
                if (m_bytes.size() > 0 && m_bytes[0] == 8'hF4) begin
                    if (m_bytes.size() == 5) begin
                        msk = {m_bytes[1], m_bytes[2]};
                        st  = {m_bytes[3], m_bytes[4]};
                        nb  = (m_btn & ~msk) | (st & msk);
                        diff = nb ^ m_btn;
                        m_btn = nb;
                        m_valid = 1'b1;
                    end else m_err = 1'b1;
                end
                m_inf = 1'b0;
            end
            if (csn_fall) begin
                m_inf = 1'b1;
                m_bytes.delete();
            end
            m_pend = (m_pend & ~clr) ^ diff;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(pe);
        end
    end

    always @(negedge clk) begin
        chk("btn_state", 32'(btn_state), 32'(m_btn));
        chk("btn_valid", 32'(btn_valid), 32'(m_valid));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
        if (evt_valid && evt_ready) popped.push_back(evt_data);
        if (frame_err) err_seen++;
    end

    always @(posedge clk) begin
        #2;
        evt_ready = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input bit merge, input int gap);
        csn_fall = 1'b1;
        tick();
        csn_fall = 1'b0;
        foreach (fr[i]) begin
            usr_mosi_stb = 1'b1;
            usr_mosi_data = fr[i];
            if (merge && i == fr.size() - 1) csn_rise = 1'b1;
            tick();
            usr_mosi_stb = 1'b0;
            csn_rise = 1'b0;
            repeat (gap) tick();
        end
        if (!(merge && fr.size() > 0)) begin
            csn_rise = 1'b1;
            tick();
            csn_rise = 1'b0;
        end
        tick();
    endtask

    task automatic send_abort();
        csn_fall = 1'b1;
        tick();
        csn_fall = 1'b0;
        repeat (2) begin
            usr_mosi_stb = 1'b1;
            usr_mosi_data = 8'hF4;
            tick();
            usr_mosi_stb = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_q.size() != 0 || m_pend != 0 || evt_valid) && n < 400) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("drain_bound", 32'(n < 400), 32'd1);
    endtask

    initial begin
        logic [15:0] seen;
        int len;
        tick();
        tick();
        chk("rst_btn_valid", 32'(btn_valid), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        resetq = 1'b1;
        ready_mode = 1;
        tick();

        popped.delete();
        fr = '{8'hF4, 8'hFF, 8'hFF, 8'h00, 8'h05};
        send_frame(1'b0, 0);
        wait_idle();
        chk("f1_state", 32'(btn_state), 32'h0005);
        chk("f1_valid", 32'(btn_valid), 32'd1);
        chk("f1_nevt", popped.size(), 32'd2);
        if (popped.size() == 2) begin
            chk("f1_evt0", 32'(popped[0]), 32'h10);
            chk("f1_evt1", 32'(popped[1]), 32'h12);
        end
        chk("f1_noerr", err_seen, 32'd0);

        popped.delete();
        fr = '{8'hF4, 8'h00, 8'h01, 8'h00, 8'h00};
        send_frame(1'b0, 1);
        wait_idle();
        chk("f2_state", 32'(btn_state), 32'h0004);
        chk("f2_nevt", popped.size(), 32'd1);
        if (popped.size() == 1) chk("f2_evt0", 32'(popped[0]), 32'h00);

        popped.delete();
        fr = '{8'hF4, 8'hFF, 8'hFF, 8'h12};
        send_frame(1'b0, 0);
        chk("short_err", err_seen, 32'd1);
        fr = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(1'b0, 0);
        wait_idle();
        chk("badcmd_noerr", err_seen, 32'd1);
        chk("bad_state", 32'(btn_state), 32'h0004);
        chk("bad_nevt", popped.size(), 32'd0);

        ready_mode = 0;
        tick();
        fr = '{8'hF4, 8'hFF, 8'hFF, 8'hFF, 8'hF4};
        send_frame(1'b0, 0);
        repeat (40) tick();
        chk("bp_queued", m_q.size(), 32'd8);
        chk("bp_valid", 32'(evt_valid), 32'd1);
        fr = '{8'hF4, 8'h00, 8'h08, 8'h00, 8'h08};
        send_frame(1'b0, 0);
        fr = '{8'hF4, 8'h00, 8'h08, 8'h00, 8'h00};
        send_frame(1'b0, 0);
        repeat (10) tick();
        popped.delete();
        ready_mode = 1;
        wait_idle();
        chk("bp_nevt", popped.size(), 32'd12);
        seen = '0;
        foreach (popped[i]) begin
            chk("bp_pressed", 32'(popped[i][4]), 32'd1);
            seen[popped[i][3:0]] = 1'b1;
        end
        chk("bp_set", 32'(seen), 32'hFFF0);
        chk("bp_state", 32'(btn_state), 32'hFFF4);

        ready_mode = 0;
        fr = '{8'hF4, 8'hFF, 8'hFF, 8'h00, 8'h00};
        send_frame(1'b0, 0);
        repeat (3) tick();
        csn_fall = 1'b1;
        tick();
        csn_fall = 1'b0;
        usr_mosi_stb = 1'b1;
        usr_mosi_data = 8'hF4;
        tick();
        usr_mosi_stb = 1'b0;
        resetq = 1'b0;
        #1;
        chk("arst_state", 32'(btn_state), 32'h0);
        chk("arst_valid", 32'(btn_valid), 32'd0);
        chk("arst_evt", 32'(evt_valid), 32'd0);
        chk("arst_err", 32'(frame_err), 32'd0);
        tick();
        tick();
        resetq = 1'b1;
        ready_mode = 1;
        tick();
        popped.delete();
        fr = '{8'hF4, 8'h00, 8'h03, 8'h00, 8'h02};
        send_frame(1'b0, 0);
        wait_idle();
        chk("post_state", 32'(btn_state), 32'h0002);
        chk("post_nevt", popped.size(), 32'd1);
        if (popped.size() == 1) chk("post_evt", 32'(popped[0]), 32'h11);

        ready_mode = 2;
        for (int f = 0; f < 300; f++) begin
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 5;
            fr.delete();
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            if (len > 0 && $urandom_range(0, 4) != 0) fr[0] = 8'hF4;
            if ($urandom_range(0, 9) == 0) send_abort();
            send_frame(1'($urandom), $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) tick();
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
